// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int N_DEF = 32;
    localparam int M_DEF = 10;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
module mem_lane_align
    import mem_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [1:0]   size_i,
    input  logic [1:0]   off_i,
    input  logic [N-1:0] wdata_i,
    input  logic         unsigned_i,
    input  logic [N-1:0] word_i,
    output logic [N-1:0] mask_o,
    output logic [N-1:0] wdata_o,
    output logic [N-1:0] rdata_o,
    output logic         misaligned_o
);

    logic [4:0]   shamt;
    logic [N-1:0] shifted;

    assign shamt   = {off_i, 3'b000};
    assign shifted = word_i >> shamt;

    // Size 3 falls into the default arm and behaves as a word access.
    always_comb begin
        mask_o       = '1;
        wdata_o      = wdata_i;
        rdata_o      = shifted;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: begin
                mask_o       = {{(N-8){1'b0}}, 8'hFF} << shamt;
                wdata_o      = {{(N-8){1'b0}}, wdata_i[7:0]} << shamt;
                rdata_o      = unsigned_i ? {{(N-8){1'b0}}, shifted[7:0]}
                                          : {{(N-8){shifted[7]}}, shifted[7:0]};
                misaligned_o = 1'b0;
            end
            SIZE_H: begin
                mask_o       = {{(N-16){1'b0}}, 16'hFFFF} << shamt;
                wdata_o      = {{(N-16){1'b0}}, wdata_i[15:0]} << shamt;
                rdata_o      = unsigned_i ? {{(N-16){1'b0}}, shifted[15:0]}
                                          : {{(N-16){shifted[15]}}, shifted[15:0]};
                misaligned_o = off_i[0];
            end
            default: begin
                mask_o       = '1;
                wdata_o      = wdata_i;
                rdata_o      = shifted;
                misaligned_o = (off_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data beats fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [M+1:0] i_addr,
    output logic         i_gnt,
    output logic         i_valid,
    output logic [N-1:0] i_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [1:0]   d_size,
    input  logic         d_unsigned,
    input  logic [M+1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_gnt,
    output logic         d_valid,
    output logic         d_err,
    output logic [N-1:0] d_rdata,
    output logic [M+1:0] mem_address,
    output logic [N-1:0] mem_mask,
    output logic [N-1:0] mem_w,
    input  logic [N-1:0] mem_v
);

    localparam logic [M+1:0] WORD_MASK = ~(M+2)'(3);

    state_t       state_q, state_d;
    logic         served_d_q, served_d_d;
    logic         err_q, err_d;
    logic [N-1:0] i_rdata_q, i_rdata_d;
    logic [N-1:0] d_rdata_q, d_rdata_d;

    logic         grant;
    logic         pick_d;
    logic [N-1:0] lane_mask;
    logic [N-1:0] lane_wdata;
    logic [N-1:0] lane_rdata;
    logic         lane_mis;

    mem_lane_align #(.N(N)) u_align (
        .size_i       (d_size),
        .off_i        (d_addr[1:0]),
        .wdata_i      (d_wdata),
        .unsigned_i   (d_unsigned),
        .word_i       (mem_v),
        .mask_o       (lane_mask),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_mis)
    );

    // Gating with rst keeps grants and write masks off while reset is held.
    assign grant = (state_q == IDLE) && (i_req || d_req) && !rst;

`ifdef MEM_ARB_RR_EN
    logic prefer_i_q, prefer_i_d;

    assign pick_d     = d_req && !(i_req && prefer_i_q);
    assign prefer_i_d = grant ? pick_d : prefer_i_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_i_q <= 1'b1;
        end else begin
            prefer_i_q <= prefer_i_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        mem_address = '0;
        mem_mask    = '0;
        mem_w       = '0;
        if (grant) begin
            if (pick_d) begin
                d_gnt       = 1'b1;
                mem_address = d_addr & WORD_MASK;
                mem_w       = lane_wdata;
                if (d_we && !lane_mis) begin
                    mem_mask = lane_mask;
                end
            end else begin
                i_gnt       = 1'b1;
                mem_address = i_addr & WORD_MASK;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        served_d_d = served_d_q;
        err_d      = err_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d    = RESP;
                    served_d_d = pick_d;
                    if (pick_d) begin
                        err_d     = lane_mis;
                        d_rdata_d = (d_we || lane_mis) ? '0 : lane_rdata;
                    end else begin
                        err_d     = 1'b0;
                        i_rdata_d = mem_v;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            served_d_q <= 1'b0;
            err_q      <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            served_d_q <= served_d_d;
            err_q      <= err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Valids decode straight from state so an async reset drops them at once.
    assign i_valid = (state_q == RESP) && !served_d_q;
    assign d_valid = (state_q == RESP) && served_d_q;
    assign d_err   = d_valid && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a byte-level memory reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N = 32;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, i_gnt, i_valid;
    logic [M+1:0] i_addr;
    logic [N-1:0] i_rdata;
    logic         d_req, d_we, d_unsigned, d_gnt, d_valid, d_err;
    logic [1:0]   d_size;
    logic [M+1:0] d_addr;
    logic [N-1:0] d_wdata, d_rdata;
    logic [M+1:0] mem_address;
    logic [N-1:0] mem_mask, mem_w, mem_v;

    mem_arbiter #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_valid     (i_valid),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_size      (d_size),
        .d_unsigned  (d_unsigned),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_valid     (d_valid),
        .d_err       (d_err),
        .d_rdata     (d_rdata),
        .mem_address (mem_address),
        .mem_mask    (mem_mask),
        .mem_w       (mem_w),
        .mem_v       (mem_v)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] addr; logic [31:0] mask; logic [31:0] w; } dg_t;
    typedef struct { logic err; logic [31:0] rdata; } dr_t;

    dg_t         dg_q[$];
    dr_t         dr_q[$];
    logic [11:0] ig_q[$];
    logic [31:0] ir_q[$];

    logic [7:0]  ref_mem [0:4095];
    logic [31:0] mem_arr [0:1023];

    int checks = 0;
    int errors = 0;
    int n_dg = 0;
    int n_ig = 0;
    bit last_d = 1'b1;

    // Memory environment: combinational read, masked write on the clock edge.
    assign mem_v = mem_arr[mem_address[11:2]];

    initial begin
        #1;
        for (int w = 0; w < 1024; w++)
            mem_arr[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
        forever begin
            @(posedge clk);
            if (mem_mask != 0)
                mem_arr[mem_address[11:2]] <= (mem_arr[mem_address[11:2]] & ~mem_mask) | (mem_w & mem_mask);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_data(input logic we, input logic [1:0] sz, input logic uns,
                                       input int a, input logic [31:0] wd);
        int          nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bit          mis = (a % nb) != 0;
        dg_t         g;
        dr_t         r;
        logic [31:0] val = 32'h0;
        g.addr  = 12'((a / 4) * 4);
        g.mask  = 32'h0;
        g.w     = 32'h0;
        r.err   = mis;
        r.rdata = 32'h0;
        if (!mis) begin
            for (int b = 0; b < nb; b++) begin
                int lane = (a % 4) + b;
                if (we) begin
                    g.mask |= 32'hFF << (8 * lane);
                    g.w    |= 32'(wd[8*b +: 8]) << (8 * lane);
                    ref_mem[a + b] = wd[8*b +: 8];
                end else begin
                    val |= 32'(ref_mem[a + b]) << (8 * b);
                end
            end
            if (!we) begin
                if (nb < 4 && !uns && val[8*nb-1]) val |= 32'hFFFF_FFFF << (8 * nb);
                r.rdata = val;
            end
        end
        dg_q.push_back(g);
        dr_q.push_back(r);
    endfunction

    function automatic void model_fetch(input int a);
        int base = (a / 4) * 4;
        ig_q.push_back(12'(base));
        ir_q.push_back({ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]});
    endfunction

    task automatic wait_gnt(input bit is_d);
        int n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (is_d ? d_gnt : i_gnt) break;
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout port=%s: got no grant, expected one within 50 cycles", is_d ? "d" : "i");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic data_issue(input logic we, input logic [1:0] sz, input logic uns,
                              input int a, input logic [31:0] wd);
        d_we = we; d_size = sz; d_unsigned = uns; d_addr = 12'(a); d_wdata = wd;
        d_req = 1'b1;
        wait_gnt(1'b1);
        d_req = 1'b0;
    endtask

    task automatic fetch_issue(input int a);
        i_addr = 12'(a);
        i_req  = 1'b1;
        wait_gnt(1'b0);
        i_req  = 1'b0;
    endtask

    task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                           input int a, input logic [31:0] wd);
        model_data(we, sz, uns, a, wd);
        last_d = 1'b1;
        data_issue(we, sz, uns, a, wd);
        @(posedge clk); #1;
    endtask

    task automatic fetch_op(input int a);
        model_fetch(a);
        last_d = 1'b0;
        fetch_issue(a);
        @(posedge clk); #1;
    endtask

    task automatic pair_op(input logic we, input logic [1:0] sz, input logic uns,
                           input int a, input logic [31:0] wd, input int fa);
`ifdef MEM_ARB_RR_EN
        bit d_first = !last_d;
`else
        bit d_first = 1'b1;
`endif
        model_data(we, sz, uns, a, wd);
        model_fetch(fa);
        last_d = !d_first;
        fork
            data_issue(we, sz, uns, a, wd);
            fetch_issue(fa);
        join
        @(posedge clk); #1;
    endtask

    task automatic contention();
        int exp_d = 0;
        int exp_i = 0;
        bit win_d;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
            if (win_d) begin
                model_data(1'b0, 2'd2, 1'b0, 0, 32'h0);
                exp_d++;
            end else begin
                model_fetch(32'h010);
                exp_i++;
            end
            last_d = win_d;
        end
        n_dg = 0;
        n_ig = 0;
        d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 12'h000; d_wdata = 32'h0;
        i_addr = 12'h010;
        d_req = 1'b1;
        i_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        d_req = 1'b0;
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("contention_d_grants", n_dg, exp_d);
        chk("contention_i_grants", n_ig, exp_i);
    endtask

    task automatic reset_mid();
        model_fetch(32'h024);
        fetch_issue(32'h024);
        // Now in the response cycle: the pending response is lost to reset.
        void'(ir_q.pop_back());
        rst    = 1'b1;
        last_d = 1'b1;
        i_req  = 1'b1;
        d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 12'h300; d_wdata = 32'h1234_5678;
        d_req  = 1'b1;
        #1;
        chk("rst_i_valid", i_valid, 32'h0);
        chk("rst_gnts", {i_gnt, d_gnt}, 32'h0);
        chk("rst_mask", mem_mask, 32'h0);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        data_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        fetch_op(32'h024);
    endtask

    always @(negedge clk) begin : monitor
        dg_t         g;
        dr_t         r;
        logic [11:0] ia;
        logic [31:0] iw;
        if (!rst) begin
            chk("single_gnt", {31'h0, i_gnt & d_gnt}, 32'h0);
            chk("err_qualified", {31'h0, d_err & ~d_valid}, 32'h0);
            if (d_gnt) begin
                n_dg++;
                if (dg_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_gnt_unexpected: got d_gnt=1, expected no data grant");
                end else begin
                    g = dg_q.pop_front();
                    chk("d_mem_address", mem_address, g.addr);
                    chk("d_mem_mask", mem_mask, g.mask);
                    chk("d_mem_w", mem_w & g.mask, g.w);
                end
            end else begin
                chk("mask_zero", mem_mask, 32'h0);
            end
            if (i_gnt) begin
                n_ig++;
                if (ig_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL i_gnt_unexpected: got i_gnt=1, expected no fetch grant");
                end else begin
                    ia = ig_q.pop_front();
                    chk("i_mem_address", mem_address, ia);
                end
            end
            if (d_valid) begin
                if (dr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_valid_unexpected: got d_valid=1, expected no data response");
                end else begin
                    r = dr_q.pop_front();
                    chk("d_err", d_err, r.err);
                    chk("d_rdata", d_rdata, r.rdata);
                end
            end
            if (i_valid) begin
                if (ir_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL i_valid_unexpected: got i_valid=1, expected no fetch response");
                end else begin
                    iw = ir_q.pop_front();
                    chk("i_rdata", i_rdata, iw);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_unsigned = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        i_req = 1'b1;
        #12;
        chk("rst_hold_i_gnt", {31'h0, i_gnt}, 32'h0);
        chk("rst_hold_mask", mem_mask, 32'h0);
        i_req = 1'b0;
        #10 rst = 1'b0;
        #1;
        chk("reset_valids", {i_valid, d_valid, d_err, i_gnt, d_gnt}, 32'h0);
        chk("reset_i_rdata", i_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        chk("reset_mask", mem_mask, 32'h0);
        @(posedge clk); #1;

        data_op(1'b1, 2'd2, 1'b0, 32'h000, 32'hCAFE_BABE);
        data_op(1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
        data_op(1'b1, 2'd1, 1'b0, 32'h002, 32'hDEAD_BEEF);
        data_op(1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
        data_op(1'b0, 2'd1, 1'b0, 32'h002, 32'h0);
        data_op(1'b0, 2'd1, 1'b1, 32'h002, 32'h0);
        data_op(1'b1, 2'd0, 1'b0, 32'hFF3, 32'h17);
        data_op(1'b1, 2'd0, 1'b0, 32'hFF3, 32'h80);
        data_op(1'b0, 2'd0, 1'b0, 32'hFF3, 32'h0);
        data_op(1'b0, 2'd0, 1'b1, 32'hFF3, 32'h0);
        data_op(1'b0, 2'd2, 1'b0, 32'h002, 32'h0);
        data_op(1'b1, 2'd1, 1'b0, 32'h001, 32'h0000_FFFF);
        data_op(1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
        data_op(1'b1, 2'd3, 1'b0, 32'h020, 32'h8765_4321);
        data_op(1'b0, 2'd3, 1'b1, 32'h020, 32'h0);

        for (int k = 0; k < 40; k++) begin
            int          kind = int'($urandom_range(0, 2));
            logic        we   = 1'($urandom_range(0, 1));
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic        uns  = 1'($urandom_range(0, 1));
            int          a    = 32'h100 + int'($urandom_range(0, 63));
            logic [31:0] wd   = $urandom;
            int          fa   = 32'h200 + int'($urandom_range(0, 255));
            if (kind == 0)      data_op(we, sz, uns, a, wd);
            else if (kind == 1) fetch_op(fa);
            else                pair_op(we, sz, uns, a, wd, fa);
        end

        fetch_op(32'h014);
        contention();
        reset_mid();

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", dg_q.size() + dr_q.size() + ig_q.size() + ir_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port byte-addressed `memory` block between the CPU's instruction-fetch port and its load/store data port.
- Arbitrates between the two requesters and converts data-port byte/half/word accesses into the memory's word address, bit-mask and shifted write data.
- Extracts, sign-extends or zero-extends load results.
- Sits between the core pipeline and `memory`.

Parameters:
- N, 32, data width in bits; fixed to 32 by the size encoding.
- M, 10, log2 of memory depth in words; byte address width is M+2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request; held with i_addr until i_gnt.
- i_addr  in  M+2  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_valid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  N  fetched word.
- d_req  in  1  data request; held with operands until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- d_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- d_addr  in  M+2  data byte address.
- d_wdata  in  N  store data, right-aligned.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  one-cycle pulse: access complete.
- d_err  out  1  qualifies d_valid: misaligned access, no memory effect.
- d_rdata  out  N  load result, extended; 0 for stores and errors.
- mem_address  out  M+2  to memory; low two bits always 0.
- mem_mask  out  N  per-bit write enable to memory; 0 means read.
- mem_w  out  N  write data to memory, lane-shifted.
- mem_v  in  N  memory read word, combinational from mem_address.

Behaviour:
- FSM states:
  - IDLE: arbitrate. If any request is pending, assert the winner's gnt combinationally, drive the memory that cycle, then go to RESP. If no request is pending, stay in IDLE with mem_mask=0 and mem_address=0.
  - RESP: assert the winner's valid (and d_err if applicable) for exactly one cycle. No grant is issued and mem_mask=0. Return to IDLE.
- Latency and throughput: the grant cycle is T, the response comes at T+1, and at most one access completes every 2 cycles.
- The read word mem_v is captured at the end of the grant cycle.
- Only one gnt is asserted per grant cycle; a requester that loses keeps req high.
- Arbitration, default (fixed priority): data wins over instruction.
- Fetch accesses: the word address is i_addr with bits [1:0] forced to 0, and the access is always a read.
- Store lane rules, with off = addr[1:0]*8:
  - byte: mask = 0xFF<<off, data = wdata[7:0]<<off.
  - half: mask = 0xFFFF<<off, data = wdata[15:0]<<off.
  - word: mask = all ones, data = wdata.
- Load: take mem_v>>off, keep the low 8, 16 or 32 bits, then extend per d_unsigned.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - The request is still granted but drives mem_mask=0.
  - In RESP: d_valid=1, d_err=1, d_rdata=0.
- Reset values: state IDLE, all gnt/valid/err outputs 0, rdata registers 0, mem_mask 0, round-robin pointer favours instruction.
- Reset asserted mid-access: the response is lost, valid drops immediately, and the requester re-issues after reset.
- While rst is high, both gnt outputs and mem_mask are forced to 0, so no spurious write can occur.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined: round-robin arbitration. A one-bit pointer flips to the other requester after each grant. On simultaneous requests, the requester not served last wins. A lone requester is always granted, with no idle cycle inserted.
- When undefined: fixed priority, data over instruction; the pointer register is not built.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef size_t: SIZE_B=0, SIZE_H=1, SIZE_W=2.
  - typedef state_t: IDLE, RESP.
  - constants N_DEF=32, M_DEF=10.
- Sub-module mem_lane_align is combinational:
  - Store side: size and offset in, mask and shifted data out.
  - Load side: word, size, offset and unsigned in, extended result out.
  - Misalignment flag out.

Test Plan:
- Word store then load: data sw 0xcafebabe @0x000, then lw @0x000 -> d_valid at T+1 with d_err=0; load returns d_rdata=0xcafebabe.
- Half store: sh 0xdeadbeef @0x002 -> mem_mask=0xffff0000, mem_w=0xbeef0000. Following lw @0x000 -> 0xbeefbabe. lh @0x002 -> 0xffffbeef. lhu @0x002 -> 0x0000beef.
- Byte lanes: sb 0x17 @0xff3 -> mask 0xff000000. Then lb/lbu @0xff3 on word 0x80xxxxxx (set via sb 0x80) -> 0xffffff80 and 0x00000080.
- Misaligned: lw @0x002 and sh @0x001 -> d_valid=1, d_err=1, d_rdata=0, mem_mask stays 0 (no memory change).
- Contention: i_req and d_req held high for 8 cycles.
  - Without MEM_ARB_RR_EN: 4 data grants, 0 fetch grants.
  - With MEM_ARB_RR_EN: grants alternate d,i,d,i; i_rdata matches preloaded words.
- Reset during RESP: rst pulse of 3ns in RESP -> valid falls immediately, mem_mask=0 throughout, and the next fetch after release completes normally.
